div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 30 +++
 rtl/div_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_WB
  } div_state_t;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Accept-to-RFWr cycles for divide-by-zero and signed overflow.
  localparam int FAST_LAT = 2;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration, purely combinational.
module div_step
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] nxt_rem,
  output logic [XLEN-1:0] nxt_quo
);

  logic [XLEN:0] sh;
  logic [XLEN:0] diff;

  always_comb begin
    sh   = {rem, quo[XLEN-1]};
    diff = sh - {1'b0, dvs};
    // A borrow out of the top bit means the trial subtraction went negative.
    if (diff[XLEN]) begin
      nxt_rem = sh[XLEN-1:0];
      nxt_quo = {quo[XLEN-2:0], 1'b0};
    end else begin
      nxt_rem = diff[XLEN-1:0];
      nxt_quo = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU: RFWr XLEN+3 cycles after accept (2 for /0 or overflow); start ignored while busy.
// Signed DIV/REM only when DIV_SIGNED_EN is defined; otherwise every op is unsigned.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            RFWr,
  output logic [31:0]     wR,
  output logic [XLEN-1:0] wD
);

  div_state_t state, nstate;

  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, res_q;
  logic [XLEN-1:0] nxt_rem, nxt_quo;
  logic [5:0]      cnt;
  logic            qneg, rneg, wb_q;
  logic            accept, is_rem, divzero;
  logic            sgn, ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  assign accept  = start && !busy;
  assign is_rem  = op_q[1];
  assign divzero = (b_q == '0);

`ifdef DIV_SIGNED_EN
  assign sgn   = ~op_q[0];
  assign abs_a = (sgn && a_q[XLEN-1]) ? -a_q : a_q;
  assign abs_b = (sgn && b_q[XLEN-1]) ? -b_q : b_q;
  assign ovf   = sgn && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
`else
  logic unused_op;
  assign unused_op = op_q[0];
  assign sgn   = 1'b0;
  assign abs_a = a_q;
  assign abs_b = b_q;
  assign ovf   = 1'b0;
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .nxt_rem (nxt_rem),
    .nxt_quo (nxt_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (accept) nstate = S_PREP;
      S_PREP: nstate = (divzero || ovf) ? S_WB : S_CALC;
      S_CALC: if (cnt == 6'(XLEN - 1)) nstate = S_FIX;
      S_FIX:  nstate = S_WB;
      S_WB:   nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      RFWr <= 1'b0;
      wR   <= '0;
      wD   <= '0;
      cnt  <= '0;
      wb_q <= 1'b0;
    end else begin
      // Outputs are registered, so the pulse lands the cycle after the WB state.
      wb_q <= (state == S_WB);
      RFWr <= (state == S_WB) && (rd_q != 5'd0);
      if (state == S_WB) begin
        wR <= {27'b0, rd_q};
        wD <= res_q;
      end
      if (wb_q)        busy <= 1'b0;
      else if (accept) busy <= 1'b1;

      case (state)
        S_IDLE: if (accept) begin
          op_q <= op;
          a_q  <= src1;
          b_q  <= src2;
          rd_q <= rd;
        end
        S_PREP: begin
          quo_q <= abs_a;
          dvs_q <= abs_b;
          rem_q <= '0;
          cnt   <= '0;
          qneg  <= sgn && (a_q[XLEN-1] ^ b_q[XLEN-1]);
          rneg  <= sgn && a_q[XLEN-1];
          if (divzero)  res_q <= is_rem ? a_q : '1;
          else if (ovf) res_q <= is_rem ? '0 : a_q;
        end
        S_CALC: begin
          rem_q <= nxt_rem;
          quo_q <= nxt_quo;
          cnt   <= cnt + 6'd1;
        end
        S_FIX: begin
          if (is_rem) res_q <= rneg ? -rem_q : rem_q;
          else        res_q <= qneg ? -quo_q : quo_q;
        end
        default: ;
      endcase
    end
  end

endmodule
